// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Brief    : Shared widths, lane packing and saturation bounds for nn stages.
// Revision : 1.0
// ============================================================================
package nn_pkg;

   localparam int DEF_LANES    = 4;
   localparam int DEF_IN_W     = 24;
   localparam int DEF_BIAS_W   = 16;
   localparam int DEF_OUT_W    = 8;
   localparam int DEF_NUM_BIAS = 16;
   localparam int DEF_SHIFT    = 4;

   // Lane i of a packed beat occupies bits [i*w +: w].
   function automatic int lane_lsb(input int lane, input int w);
      return lane * w;
   endfunction

   function automatic longint sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/bias_lane.sv
`default_nettype none
// ============================================================================
// Module   : bias_lane
// Brief    : One lane of bias add, arithmetic shift, optional ReLU, saturate.
// Revision : 1.0
// ============================================================================
module bias_lane
   import nn_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int BIAS_W = DEF_BIAS_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int SHIFT  = DEF_SHIFT
) (
   input  logic signed [IN_W-1:0]   acc,
   input  logic signed [BIAS_W-1:0] bias,
   input  logic                     relu,
   output logic signed [OUT_W-1:0]  res
);

   // One guard bit above the wider operand makes the sum overflow-free.
   localparam int     c_sum_w = ((IN_W > BIAS_W) ? IN_W : BIAS_W) + 1;
   localparam longint c_hi    = sat_hi(OUT_W);
   localparam longint c_lo    = sat_lo(OUT_W);

   logic signed [c_sum_w-1:0] w_sum;
   logic signed [c_sum_w-1:0] w_shift;
   logic signed [63:0]        w_wide;

   assign w_sum   = c_sum_w'(acc) + c_sum_w'(bias);
   assign w_shift = w_sum >>> SHIFT;

   always_comb begin
      w_wide = 64'(w_shift);
      if (relu && (w_shift < 0)) begin
         w_wide = '0;
      end
      res = OUT_W'(w_wide);
      if (w_wide > c_hi) begin
         res = OUT_W'(c_hi);
      end else if (w_wide < c_lo) begin
         res = OUT_W'(c_lo);
      end
   end

endmodule
`default_nettype wire

// File: rtl/nn_bias_adder.sv
`default_nettype none
// ============================================================================
// Module   : nn_bias_adder
// Brief    : Per-channel bias add and requantize, one registered output stage.
// Revision : 1.0
// ============================================================================
module nn_bias_adder
   import nn_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int IN_W     = DEF_IN_W,
   parameter int BIAS_W   = DEF_BIAS_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int NUM_BIAS = DEF_NUM_BIAS,
   parameter int SHIFT    = DEF_SHIFT,
   parameter int IDX_W    = $clog2(NUM_BIAS)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    bias_wr_en,
   input  logic [IDX_W-1:0]        bias_wr_addr,
   input  logic [BIAS_W-1:0]       bias_wr_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*IN_W-1:0]   in_data,
   input  logic [IDX_W-1:0]        in_chan,
   input  logic                    in_relu,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*OUT_W-1:0]  out_data,
   output logic [IDX_W-1:0]        out_chan
);

   localparam logic [IDX_W:0] c_num_bias = (IDX_W + 1)'(NUM_BIAS);

   logic signed [BIAS_W-1:0]  r_bias [NUM_BIAS];
   logic                      r_valid;
   logic [LANES*OUT_W-1:0]    r_data;
   logic [IDX_W-1:0]          r_chan;

   logic                      w_xfer;
   logic signed [BIAS_W-1:0]  w_bias;
   logic [LANES*OUT_W-1:0]    w_res;

   assign in_ready = !r_valid || out_ready;
   assign w_xfer   = in_valid && in_ready;

   // Read before the edge, so a same-cycle write is seen only by later beats.
   assign w_bias = ({1'b0, in_chan} < c_num_bias) ? r_bias[in_chan] : '0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_BIAS; i++) begin
            r_bias[i] <= '0;
         end
      end else if (bias_wr_en && ({1'b0, bias_wr_addr} < c_num_bias)) begin
         r_bias[bias_wr_addr] <= bias_wr_data;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lanes
         bias_lane #(
            .IN_W   (IN_W),
            .BIAS_W (BIAS_W),
            .OUT_W  (OUT_W),
            .SHIFT  (SHIFT)
         ) u_lane (
            .acc  (in_data[lane_lsb(i, IN_W) +: IN_W]),
            .bias (w_bias),
            .relu (in_relu),
            .res  (w_res[lane_lsb(i, OUT_W) +: OUT_W])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_res;
         r_chan  <= in_chan;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_chan  = r_chan;

endmodule
`default_nettype wire

// File: tb/tb_nn_bias_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_bias_adder
// Brief    : Directed plus randomized self-checking bench for nn_bias_adder.
// Revision : 1.0
// ============================================================================
module tb_nn_bias_adder;

   localparam int LANES    = 4;
   localparam int IN_W     = 24;
   localparam int BIAS_W   = 16;
   localparam int OUT_W    = 8;
   localparam int NUM_BIAS = 16;
   localparam int SHIFT    = 4;
   localparam int IDX_W    = 4;
   localparam int DW       = LANES * IN_W;
   localparam int OW       = LANES * OUT_W;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              bias_wr_en;
   logic [IDX_W-1:0]  bias_wr_addr;
   logic [BIAS_W-1:0] bias_wr_data;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic [IDX_W-1:0]  in_chan;
   logic              in_relu;
   logic              out_valid;
   logic              out_ready;
   logic [OW-1:0]     out_data;
   logic [IDX_W-1:0]  out_chan;

   always #5 clk = ~clk;

   nn_bias_adder #(
      .LANES(LANES), .IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W),
      .NUM_BIAS(NUM_BIAS), .SHIFT(SHIFT), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .n_rst(n_rst),
      .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_chan(in_chan), .in_relu(in_relu),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_chan(out_chan)
   );

   typedef struct {
      logic [OW-1:0]    data;
      logic [IDX_W-1:0] chan;
   } beat_t;

   beat_t exp_q[$];
   int    model_bias [NUM_BIAS];
   int    checks   = 0;
   int    failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer math, floor division for the arithmetic shift.
   function automatic logic [OW-1:0] ref_beat(input logic [DW-1:0] d, input int b, input bit relu);
      logic [OW-1:0]          r;
      logic signed [IN_W-1:0] a;
      longint                 s, q, hi, lo, div;
      div = longint'(1) << SHIFT;
      hi  = (longint'(1) << (OUT_W - 1)) - 1;
      lo  = -(longint'(1) << (OUT_W - 1));
      r   = '0;
      for (int i = 0; i < LANES; i++) begin
         a = d[i*IN_W +: IN_W];
         s = longint'(a) + longint'(b);
         if (s >= 0) q = s / div;
         else        q = -((-s + div - 1) / div);
         if (relu && q < 0) q = 0;
         if (q > hi) q = hi;
         if (q < lo) q = lo;
         r[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
      end
      return r;
   endfunction

   // One clock of stimulus; checks outputs before and after the edge against the model.
   task automatic cycle(input bit v, input logic [IDX_W-1:0] ch, input logic [DW-1:0] d,
                        input bit relu, input bit ordy, input bit wen,
                        input logic [IDX_W-1:0] wa, input logic [BIAS_W-1:0] wd,
                        output bit xfer);
      beat_t b;
      bit    held;
      in_valid = v; in_chan = ch; in_data = d; in_relu = relu; out_ready = ordy;
      bias_wr_en = wen; bias_wr_addr = wa; bias_wr_data = wd;
      #1;
      held = (exp_q.size() != 0);
      check("in_ready", in_ready, !held || ordy);
      if (held) begin
         check("out_data", out_data, exp_q[0].data);
         check("out_chan", out_chan, exp_q[0].chan);
      end
      xfer = v && (!held || ordy);
      if (held && ordy) void'(exp_q.pop_front());
      if (xfer) begin
         b.data = ref_beat(d, model_bias[ch], relu);
         b.chan = ch;
         exp_q.push_back(b);
      end
      if (wen) model_bias[wa] = int'($signed(wd));
      @(posedge clk);
      #1;
      check("out_valid", out_valid, exp_q.size() != 0);
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0]     d;
      logic [IN_W-1:0]   v;
      for (int i = 0; i < LANES; i++) begin
         case ($urandom_range(0, 2))
            0:       v = IN_W'($urandom);
            1:       v = IN_W'(int'($urandom_range(0, 8191)) - 4096);
            default: v = IN_W'(int'($urandom_range(0, 63)) - 32);
         endcase
         d[i*IN_W +: IN_W] = v;
      end
      return d;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            x;
      int            acc, k;
      logic [DW-1:0] d;
      logic [IDX_W-1:0] ch;
      bit            rl;

      n_rst = 1'b0; in_valid = 0; in_data = '0; in_chan = '0; in_relu = 0;
      out_ready = 0; bias_wr_en = 0; bias_wr_addr = '0; bias_wr_data = '0;
      for (int i = 0; i < NUM_BIAS; i++) model_bias[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_chan", out_chan, '0);
      n_rst = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      // Unwritten entry 5 holds zero: 160 >>> 4 = 10.
      d = '0; d[23:0] = 24'd160;
      cycle(1, 4'd5, d, 0, 0, 0, '0, '0, x);
      check("zero_bias_lane0", out_data[7:0], 8'd10);
      check("zero_bias_chan", out_chan, 4'd5);
      cycle(0, '0, '0, 0, 1, 0, '0, '0, x);

      // bias[3]=16, lanes {64,-200,0,15} -> {5,-12,1,1}
      cycle(0, '0, '0, 0, 1, 1, 4'd3, 16'd16, x);
      d = {24'sd15, 24'sd0, -24'sd200, 24'sd64};
      cycle(1, 4'd3, d, 0, 0, 0, '0, '0, x);
      check("bias_add_data", out_data, 32'h0101F405);
      check("bias_add_chan", out_chan, 4'd3);
      cycle(0, '0, '0, 0, 1, 0, '0, '0, x);

      // Saturation, then the same beat with ReLU loaded on a simultaneous drain.
      d = {24'sd2047, -24'sd200, -24'sd10000, 24'sd10000};
      cycle(1, 4'd0, d, 0, 0, 0, '0, '0, x);
      check("sat_norelu", out_data, 32'h7FF3807F);
      cycle(1, 4'd0, d, 1, 1, 0, '0, '0, x);
      check("sat_relu", out_data, 32'h7F00007F);
      cycle(0, '0, '0, 0, 1, 0, '0, '0, x);

      // Backpressure: out_ready 1,0,0,1 repeating; each beat held until accepted.
      acc = 0; k = 0;
      d = rand_data(); ch = IDX_W'($urandom); rl = 1'($urandom);
      while (acc < 8 && k < 100) begin
         cycle(1, ch, d, rl, (k % 4 == 0) || (k % 4 == 3), 0, '0, '0, x);
         if (x) begin
            acc++;
            d = rand_data(); ch = IDX_W'($urandom); rl = 1'($urandom);
         end
         k++;
      end
      check("bp_accepted", acc, 8);
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         cycle(0, '0, '0, 0, 1, 0, '0, '0, x);
         k++;
      end

      // Same-cycle write and use of bias[2]: old value wins.
      cycle(0, '0, '0, 0, 1, 1, 4'd2, 16'd0, x);
      cycle(1, 4'd2, '0, 0, 1, 1, 4'd2, 16'd32, x);
      check("collide_old", out_data[7:0], 8'd0);
      cycle(1, 4'd2, '0, 0, 1, 0, '0, '0, x);
      check("collide_new", out_data[7:0], 8'd2);
      cycle(0, '0, '0, 0, 1, 0, '0, '0, x);

      // Random traffic, bias writes interleaved.
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 3) != 0, IDX_W'($urandom), rand_data(), 1'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
               IDX_W'($urandom), BIAS_W'($urandom), x);
      end
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         cycle(0, '0, '0, 0, 1, 0, '0, '0, x);
         k++;
      end

      // Asynchronous reset while a beat is stalled.
      cycle(0, '0, '0, 0, 1, 1, 4'd3, 16'd50, x);
      d = '0; d[23:0] = 24'd160;
      cycle(1, 4'd3, d, 0, 0, 0, '0, '0, x);
      #2;
      n_rst = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, '0);
      exp_q.delete();
      for (int i = 0; i < NUM_BIAS; i++) model_bias[i] = 0;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      #1;
      cycle(1, 4'd3, d, 0, 0, 0, '0, '0, x);
      check("midrst_bias_cleared", out_data[7:0], 8'd10);
      cycle(0, '0, '0, 0, 1, 0, '0, '0, x);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
